// File: rtl/mem_access_stage_pkg.sv
// Shared control-vector bit positions and memory-stage FSM encoding.
// Decode and execute use the same bit indices.
package mem_access_stage_pkg;

    localparam int SIG_ALUSRC   = 7;
    localparam int SIG_MEMTOREG = 6;
    localparam int SIG_REGWRITE = 5;
    localparam int SIG_MEMREAD  = 4;
    localparam int SIG_MEMWRITE = 3;
    localparam int SIG_BRANCH   = 2;
    localparam int SIG_EQ       = 1;
    localparam int SIG_GOTO     = 0;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } mem_state_e;

    // Per-instruction control carried alongside an outstanding request.
    typedef struct packed {
        logic                 we;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic [REG_IDX_W-1:0] dest;
    } req_ctrl_t;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_stage_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge. expired fires in the
// cycle whose edge brings the count to TIMEOUT-1, so a request is held TIMEOUT cycles total.
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues LW/SW over a req/ack port, stalls upstream
// while a transaction is outstanding, and registers the write-back bundle.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     store_data,
    input  logic [REG_IDX_W-1:0] destination,
    input  logic [7:0]           signals,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic                 mem_ack,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_IDX_W-1:0] wb_dest,
    output logic [WIDTH-1:0]     wb_data,
    output logic                 bus_error
);

    mem_state_e           state_q, state_d;
    logic [WIDTH-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    req_ctrl_t            ctrl_q, ctrl_d;
    logic                 wb_valid_q, wb_valid_d;
    logic                 wb_reg_write_q, wb_reg_write_d;
    logic [REG_IDX_W-1:0] wb_dest_q, wb_dest_d;
    logic [WIDTH-1:0]     wb_data_q, wb_data_d;
    logic                 bus_error_q, bus_error_d;

    req_ctrl_t        in_ctrl, cur_ctrl;
    logic [WIDTH-1:0] cur_addr;
    logic             is_mem_op, is_aligned, idle_req, waiting, retire, timer_expired;
    logic             unused_sigs;

    // A store never writes the register file, even if reg_write is also set.
    assign in_ctrl = '{we:         signals[SIG_MEMWRITE],
                       mem_to_reg: signals[SIG_MEMTOREG],
                       reg_write:  signals[SIG_REGWRITE] & ~signals[SIG_MEMWRITE],
                       dest:       destination};

    assign is_mem_op  = signals[SIG_MEMREAD] | signals[SIG_MEMWRITE];
    assign is_aligned = word_aligned(alu_result[1:0]);
    assign idle_req   = reset && (state_q == ST_IDLE) && in_valid && is_mem_op && is_aligned;
    assign waiting    = reset && (state_q == ST_WAIT_ACK);
    assign cur_ctrl   = waiting ? ctrl_q : in_ctrl;
    assign cur_addr   = waiting ? addr_q : alu_result;
    assign retire     = mem_req & mem_ack;

    assign mem_req   = idle_req | waiting;
    assign mem_we    = mem_req & cur_ctrl.we;
    assign mem_addr  = mem_req ? cur_addr : '0;
    assign mem_wdata = mem_req ? (waiting ? wdata_q : store_data) : '0;
    assign stall     = mem_req & ~mem_ack;

    assign unused_sigs = ^{signals[SIG_ALUSRC], signals[SIG_BRANCH], signals[SIG_EQ],
                           signals[SIG_GOTO]};

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (idle_req),
        .enable  (state_q == ST_WAIT_ACK),
        .expired (timer_expired)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path can infer a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        ctrl_d         = ctrl_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_dest_d      = wb_dest_q;
        wb_data_d      = wb_data_q;
        bus_error_d    = bus_error_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && !is_mem_op) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = signals[SIG_REGWRITE];
                    wb_dest_d      = destination;
                    wb_data_d      = alu_result;
                end else if (in_valid && !is_aligned) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_dest_d      = destination;
                    wb_data_d      = alu_result;
                    bus_error_d    = 1'b1;
                end else if (idle_req && !mem_ack) begin
                    state_d = ST_WAIT_ACK;
                    addr_d  = alu_result;
                    wdata_d = store_data;
                    ctrl_d  = in_ctrl;
                end
            end
            ST_WAIT_ACK: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else if (timer_expired) begin
                    state_d        = ST_IDLE;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_dest_d      = ctrl_q.dest;
                    wb_data_d      = addr_q;
                    bus_error_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acknowledge beats a same-cycle timeout; covers zero-wait and waited completions.
        if (retire) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = cur_ctrl.reg_write;
            wb_dest_d      = cur_ctrl.dest;
            wb_data_d      = cur_ctrl.mem_to_reg ? mem_rdata : cur_addr;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            ctrl_q         <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_dest_q      <= '0;
            wb_data_q      <= '0;
            bus_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            ctrl_q         <= ctrl_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_dest_q      <= wb_dest_d;
            wb_data_q      <= wb_data_d;
            bus_error_q    <= bus_error_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_dest      = wb_dest_q;
    assign wb_data      = wb_data_q;
    assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a request-age transaction model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_mem_access_stage;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    localparam logic [7:0] OP_ALU    = 8'h20;  // reg_write
    localparam logic [7:0] OP_LW     = 8'hF0;  // alusrc, memtoreg, reg_write, memread
    localparam logic [7:0] OP_SW     = 8'h88;  // alusrc, memwrite
    localparam logic [7:0] OP_RD_WR  = 8'hB8;  // alusrc, reg_write, memread, memwrite

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] store_data;
    logic [4:0]       destination;
    logic [7:0]       signals;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;
    logic             wb_valid;
    logic             wb_reg_write;
    logic [4:0]       wb_dest;
    logic [WIDTH-1:0] wb_data;
    logic             bus_error;

    mem_access_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .destination  (destination),
        .signals      (signals),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .bus_error    (bus_error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int req_cycles   = 0;
    int stall_cycles = 0;

    // Model: one outstanding request with its age in request-cycles, plus the expected WB bundle.
    logic        m_busy;
    int          m_age;
    logic        m_we, m_m2r, m_rw;
    logic [4:0]  m_dest;
    logic [31:0] m_addr, m_wdata;
    logic        e_valid, e_rw, e_bus_error, e_known;
    logic [4:0]  e_dest;
    logic [31:0] e_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_retire(input logic we, input logic m2r, input logic rw,
                                input logic [4:0] dst, input logic [31:0] addr);
        e_valid = 1'b1;
        e_rw    = rw & ~we;
        e_dest  = dst;
        e_data  = m2r ? mem_rdata : addr;
        e_known = 1'b1;
    endtask

    task automatic model_error();
        e_valid     = 1'b1;
        e_rw        = 1'b0;
        e_bus_error = 1'b1;
        e_known     = 1'b0;
    endtask

    // Compare every output against the model at the negedge, then advance the model.
    task automatic tick();
        logic is_mem, exp_req;
        @(negedge clock);
        is_mem  = signals[4] | signals[3];
        exp_req = reset && (m_busy || (in_valid && is_mem && alu_result[1:0] == 2'b00));
        if (mem_req) req_cycles++;
        if (stall) stall_cycles++;
        if (reset) begin
            check("mem_req", 64'(mem_req), 64'(exp_req));
            check("stall", 64'(stall), 64'(exp_req && !mem_ack));
            if (exp_req) begin
                check("mem_we", 64'(mem_we), 64'(m_busy ? m_we : signals[3]));
                check("mem_addr", 64'(mem_addr), 64'(m_busy ? m_addr : alu_result));
                check("mem_wdata", 64'(mem_wdata), 64'(m_busy ? m_wdata : store_data));
            end
        end
        check("wb_valid", 64'(wb_valid), 64'(e_valid));
        check("wb_reg_write", 64'(wb_reg_write), 64'(e_rw));
        check("bus_error", 64'(bus_error), 64'(e_bus_error));
        if (e_known) begin
            check("wb_dest", 64'(wb_dest), 64'(e_dest));
            check("wb_data", 64'(wb_data), 64'(e_data));
        end

        if (!reset) begin
            m_busy = 1'b0; m_age = 0;
            e_valid = 1'b0; e_rw = 1'b0; e_dest = '0; e_data = '0;
            e_bus_error = 1'b0; e_known = 1'b1;
        end else begin
            e_valid = 1'b0;
            if (m_busy) begin
                if (mem_ack) begin
                    model_retire(m_we, m_m2r, m_rw, m_dest, m_addr);
                    m_busy = 1'b0;
                end else if (m_age >= TIMEOUT) begin
                    model_error();
                    m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end else if (in_valid) begin
                if (!is_mem) begin
                    e_valid = 1'b1; e_rw = signals[5]; e_dest = destination;
                    e_data = alu_result; e_known = 1'b1;
                end else if (alu_result[1:0] != 2'b00) begin
                    model_error();
                end else if (mem_ack) begin
                    model_retire(signals[3], signals[6], signals[5], destination, alu_result);
                end else begin
                    m_busy = 1'b1; m_age = 2;
                    m_we = signals[3]; m_m2r = signals[6]; m_rw = signals[5];
                    m_dest = destination; m_addr = alu_result; m_wdata = store_data;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] sig, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] dst);
        in_valid = v; signals = sig; alu_result = alu; store_data = sd; destination = dst;
    endtask

    initial begin
        int r0, s0;
        reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0);
        m_busy = 1'b0; m_age = 0; m_we = 1'b0; m_m2r = 1'b0; m_rw = 1'b0;
        m_dest = '0; m_addr = '0; m_wdata = '0;
        e_valid = 1'b0; e_rw = 1'b0; e_dest = '0; e_data = '0; e_bus_error = 1'b0; e_known = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_bus_error", 64'(bus_error), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        tick();

        // 1: plain ALU op, latency 1, never stalls
        s0 = stall_cycles;
        drive(1'b1, OP_ALU, 32'h2A, 32'h0, 5'd3);
        tick();
        drive(1'b0, OP_ALU, 32'h2A, 32'h0, 5'd3);
        check("t1_wb_valid", 64'(wb_valid), 64'd1);
        check("t1_wb_data", 64'(wb_data), 64'h2A);
        check("t1_wb_dest", 64'(wb_dest), 64'd3);
        check("t1_wb_reg_write", 64'(wb_reg_write), 64'd1);
        check("t1_no_stall", 64'(stall_cycles - s0), 64'd0);
        tick();

        // 2: LW acked three cycles after the request
        r0 = req_cycles; s0 = stall_cycles;
        drive(1'b1, OP_LW, 32'h100, 32'h0, 5'd5);
        repeat (3) tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; in_valid = 1'b0;
        check("t2_req_cycles", 64'(req_cycles - r0), 64'd4);
        check("t2_stall_cycles", 64'(stall_cycles - s0), 64'd3);
        check("t2_wb_data", 64'(wb_data), 64'hDEADBEEF);
        check("t2_wb_reg_write", 64'(wb_reg_write), 64'd1);
        tick();

        // 3: SW with zero-wait ack, then a read+write op where the write wins
        s0 = stall_cycles;
        drive(1'b1, OP_SW, 32'h8, 32'h55, 5'd7);
        mem_ack = 1'b1;
        #1;
        check("t3_mem_we", 64'(mem_we), 64'd1);
        check("t3_mem_wdata", 64'(mem_wdata), 64'h55);
        check("t3_mem_addr", 64'(mem_addr), 64'h8);
        tick();
        check("t3_wb_valid", 64'(wb_valid), 64'd1);
        check("t3_wb_reg_write", 64'(wb_reg_write), 64'd0);
        check("t3_no_stall", 64'(stall_cycles - s0), 64'd0);
        drive(1'b1, OP_RD_WR, 32'hC, 32'h1234, 5'd1);
        #1;
        check("t3_rdwr_we", 64'(mem_we), 64'd1);
        tick();
        mem_ack = 1'b0; in_valid = 1'b0;
        check("t3_rdwr_reg_write", 64'(wb_reg_write), 64'd0);
        tick();

        // 4: misaligned LW raises a sticky bus error without a request
        drive(1'b1, OP_LW, 32'h102, 32'h0, 5'd9);
        #1;
        check("t4_mem_req", 64'(mem_req), 64'd0);
        tick();
        in_valid = 1'b0;
        check("t4_bus_error", 64'(bus_error), 64'd1);
        check("t4_wb_valid", 64'(wb_valid), 64'd1);
        check("t4_wb_reg_write", 64'(wb_reg_write), 64'd0);
        drive(1'b1, OP_ALU, 32'h11, 32'h0, 5'd2);
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_sticky", 64'(bus_error), 64'd1);

        // 5: timeout after TIMEOUT request cycles, late ack ignored, next op normal
        reset = 1'b0;
        tick();
        reset = 1'b1;
        r0 = req_cycles;
        drive(1'b1, OP_LW, 32'h200, 32'h0, 5'd4);
        repeat (TIMEOUT) tick();
        in_valid = 1'b0;
        #1;
        check("t5_req_cycles", 64'(req_cycles - r0), 64'(TIMEOUT));
        check("t5_mem_req_dropped", 64'(mem_req), 64'd0);
        check("t5_bus_error", 64'(bus_error), 64'd1);
        check("t5_wb_valid", 64'(wb_valid), 64'd1);
        check("t5_wb_reg_write", 64'(wb_reg_write), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        tick();
        mem_ack = 1'b0;
        check("t5_late_ack", 64'(wb_valid), 64'd0);
        drive(1'b1, OP_ALU, 32'h77, 32'h0, 5'd2);
        tick();
        in_valid = 1'b0;
        check("t5_next_data", 64'(wb_data), 64'h77);
        check("t5_next_reg_write", 64'(wb_reg_write), 64'd1);

        // 7: ack arriving in the expiry cycle wins over the timeout
        r0 = req_cycles;
        drive(1'b1, OP_LW, 32'h300, 32'h0, 5'd6);
        repeat (TIMEOUT - 1) tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0; in_valid = 1'b0;
        check("t7_req_cycles", 64'(req_cycles - r0), 64'(TIMEOUT));
        check("t7_wb_data", 64'(wb_data), 64'hCAFEF00D);
        check("t7_wb_reg_write", 64'(wb_reg_write), 64'd1);
        tick();

        // 6: reset while waiting for an ack clears everything
        drive(1'b1, OP_LW, 32'h40, 32'h0, 5'd8);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("t6_mem_req", 64'(mem_req), 64'd0);
        check("t6_stall", 64'(stall), 64'd0);
        check("t6_wb_valid", 64'(wb_valid), 64'd0);
        check("t6_wb_reg_write", 64'(wb_reg_write), 64'd0);
        check("t6_wb_dest", 64'(wb_dest), 64'd0);
        check("t6_wb_data", 64'(wb_data), 64'd0);
        check("t6_bus_error", 64'(bus_error), 64'd0);
        drive(1'b1, OP_LW, 32'h44, 32'h0, 5'd10);
        mem_ack = 1'b1; mem_rdata = 32'h600D;
        tick();
        mem_ack = 1'b0; in_valid = 1'b0;
        check("t6_recover_data", 64'(wb_data), 64'h600D);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
